// File: rtl/mig_ui_responder.sv
// Behavioural stand-in for a MIG user interface: calibration delay, periodic
// backpressure, read credits and a fixed-latency in-order read return path.
module mig_ui_responder #(
   parameter int DEPTH           = 1024,
   parameter int CAL_CYCLES      = 100,
   parameter int RD_LAT          = 4,
   parameter int STALL_PERIOD    = 16,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic         ui_clk,
   input  logic         rst_n,
   input  logic [27:0]  app_addr,
   input  logic         app_en,
   input  logic [2:0]   app_cmd,
   input  logic [127:0] app_wdf_data,
   input  logic         app_wdf_wren,
   input  logic         app_wdf_end,
   output logic         init_calib_complete,
   output logic         app_rdy,
   output logic         app_wdf_rdy,
   output logic [127:0] app_rd_data,
   output logic         app_rd_data_valid,
   output logic         protocol_err,
   output logic [23:0]  wr_count,
   output logic [23:0]  rd_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(CAL_CYCLES + 1);
   localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
   localparam logic [CW-1:0] CAL_LAST = CW'(CAL_CYCLES - 1);
   localparam bit STALL_EN = (STALL_PERIOD != 0);
   localparam logic [SW-1:0] S_LAST = SW'(STALL_PERIOD - 1);
   localparam logic [SW-1:0] S_HALF = SW'(STALL_PERIOD / 2);
   localparam logic [4:0] MAX_OUT = 5'(MAX_OUTSTANDING);

   logic [127:0] mem_q [DEPTH];

   logic              cal_q, cal_d;
   logic [CW-1:0]     cal_cnt_q, cal_cnt_d;
   logic [SW-1:0]     stall_q, stall_d;
   logic [4:0]        outst_q, outst_d;
   logic              err_q, err_d;
   logic [23:0]       wr_cnt_q, wr_cnt_d;
   logic [23:0]       rd_cnt_q, rd_cnt_d;
   logic [RD_LAT-1:0] pv_q, pv_d;
   logic [127:0]      pd_q [RD_LAT];
   logic [127:0]      pd_d [RD_LAT];

   logic [AW-1:0] idx;
   logic          wr_cmd, rd_cmd, bad, wr_acc, rd_acc, ret;
   logic          unused_addr;

   assign idx         = app_addr[3+AW-1:3];
   assign unused_addr = ^{app_addr[27:3+AW], app_addr[2:0]};

   // Ready lines depend only on registered state, never on this cycle's inputs.
   assign app_rdy     = cal_q && !(STALL_EN && stall_q == S_LAST)
                        && (outst_q != MAX_OUT);
   assign app_wdf_rdy = cal_q && !(STALL_EN && stall_q == S_HALF);

   assign wr_cmd = app_en && (app_cmd == 3'd0);
   assign rd_cmd = app_en && (app_cmd == 3'd1);
   assign bad    = (app_en && (app_cmd > 3'd1) && app_rdy)
                || (app_wdf_wren && !wr_cmd)
                || (wr_cmd && !app_wdf_wren)
                || (app_wdf_end != app_wdf_wren)
                || (app_en && !cal_q);
   assign wr_acc = wr_cmd && app_wdf_wren && app_wdf_end
                && app_rdy && app_wdf_rdy && !bad;
   assign rd_acc = rd_cmd && app_rdy && !bad;
   assign ret    = pv_q[RD_LAT-1];

   assign init_calib_complete = cal_q;
   assign app_rd_data_valid   = ret;
   assign app_rd_data         = pd_q[RD_LAT-1];
   assign protocol_err        = err_q;
   assign wr_count            = wr_cnt_q;
   assign rd_count            = rd_cnt_q;

   always_comb begin
      cal_d     = cal_q;
      cal_cnt_d = cal_cnt_q;
      if (!cal_q) begin
         cal_cnt_d = cal_cnt_q + 1'b1;
         if (cal_cnt_q == CAL_LAST) cal_d = 1'b1;
      end
      stall_d = stall_q;
      if (cal_q && STALL_EN)
         stall_d = (stall_q == S_LAST) ? '0 : stall_q + 1'b1;
      outst_d  = outst_q + {4'd0, rd_acc} - {4'd0, ret};
      err_d    = err_q | bad;
      wr_cnt_d = wr_cnt_q + {23'd0, wr_acc};
      rd_cnt_d = rd_cnt_q + {23'd0, ret};
      // Data only advances with a valid beat, so the last stage holds its word.
      pv_d = pv_q;
      pd_d = pd_q;
      for (int i = RD_LAT - 1; i > 0; i--) begin
         pv_d[i] = pv_q[i-1];
         pd_d[i] = pv_q[i-1] ? pd_q[i-1] : pd_q[i];
      end
      pv_d[0] = rd_acc;
      pd_d[0] = rd_acc ? mem_q[idx] : pd_q[0];
   end

   always_ff @(posedge ui_clk or negedge rst_n) begin
      if (!rst_n) begin
         cal_q     <= 1'b0;
         cal_cnt_q <= '0;
         stall_q   <= '0;
         outst_q   <= '0;
         err_q     <= 1'b0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         pv_q      <= '0;
         for (int i = 0; i < RD_LAT; i++) pd_q[i] <= '0;
      end else begin
         cal_q     <= cal_d;
         cal_cnt_q <= cal_cnt_d;
         stall_q   <= stall_d;
         outst_q   <= outst_d;
         err_q     <= err_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         pv_q      <= pv_d;
         pd_q      <= pd_d;
      end
   end

   always_ff @(posedge ui_clk) begin
      if (wr_acc) mem_q[idx] <= app_wdf_data;
   end

endmodule

// File: doc/mig_ui_responder.md
MIG_UI_RESPONDER -- requirements
Module: mig_ui_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, the number of 128-bit memory words; it is a power of two.
REQ-002 SHALL have parameter CAL_CYCLES, default 100, the number of cycles from reset release to calibration done.
REQ-003 SHALL have parameter RD_LAT, default 4, the cycles from read acceptance to app_rd_data_valid; legal range 1..16.
REQ-004 SHALL have parameter STALL_PERIOD, default 16, the backpressure period; 0 disables stalls, and any other value is at least 4.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 8, the read-credit limit; legal range 1..16.
REQ-006 SHALL have ports in this order, as name, direction, width, meaning:
- ui_clk  in  1  the single clock.
- rst_n  in  1  asynchronous active-low reset.
- app_addr  in  28  byte/beat address.
- app_en  in  1  command valid.
- app_cmd  in  3  command: 0 = write, 1 = read.
- app_wdf_data  in  128  write data.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat of the write burst.
- init_calib_complete  out  1  calibration done.
- app_rdy  out  1  command accept ready.
- app_wdf_rdy  out  1  write data ready.
- app_rd_data  out  128  read data.
- app_rd_data_valid  out  1  read data valid.
- protocol_err  out  1  sticky protocol violation.
- wr_count  out  24  accepted writes.
- rd_count  out  24  returned reads.

Function
REQ-007 SHALL form the word index as app_addr[3+log2(DEPTH)-1:3]; higher address bits are ignored, so addresses alias modulo DEPTH.
REQ-008 SHALL count cycles after reset release and assert init_calib_complete on cycle CAL_CYCLES; init_calib_complete then stays high until reset.
REQ-009 SHALL hold app_rdy, app_wdf_rdy and app_rd_data_valid low while init_calib_complete is low.
REQ-010 SHALL run a free-running stall counter 0..STALL_PERIOD-1 once calibration is done.
- app_rdy is low when the counter equals STALL_PERIOD-1.
- app_wdf_rdy is low when the counter equals STALL_PERIOD/2.
- Both signals are otherwise high.
REQ-011 SHALL also force app_rdy low whenever the outstanding read count equals MAX_OUTSTANDING.
REQ-012 SHALL derive app_rdy and app_wdf_rdy only from registered state, never combinationally from inputs.
REQ-013 SHALL accept a write only in a cycle with app_en, app_cmd==0, app_wdf_wren, app_wdf_end, app_rdy and app_wdf_rdy all high.
- The addressed word is updated at the end of that cycle.
- wr_count increments by 1.
REQ-014 SHALL accept a read in a cycle with app_en, app_cmd==1 and app_rdy high.
- The read captures the memory contents as of that cycle's start, including any write accepted in an earlier cycle.
- The outstanding count increments.
REQ-015 SHALL pulse app_rd_data_valid exactly RD_LAT cycles after each read acceptance, with app_rd_data equal to the captured word.
- Returns are in acceptance order.
- Back-to-back reads produce back-to-back valid pulses.
REQ-016 SHALL hold app_rd_data at its last value when app_rd_data_valid is low.
REQ-017 SHALL, on each valid pulse, decrement the outstanding count and increment rd_count.
- A simultaneous accept and return leaves the outstanding count unchanged.
REQ-018 SHALL set protocol_err, ignore the offending command, and leave memory and counters unchanged in each of these cases:
- app_en high with app_cmd other than 0 or 1 while app_rdy is high.
- app_wdf_wren high without a write command in the same cycle.
- A write command without app_wdf_wren.
- app_wdf_end different from app_wdf_wren.
- app_en high before calibration is done.
REQ-019 SHALL leave a command presented while app_rdy is low unaccepted and without effect; this is not an error.
REQ-020 SHALL wrap wr_count and rd_count from 2^24-1 to 0.
REQ-021 SHALL hold protocol_err high until reset.

Reset
REQ-022 SHALL, while rst_n is low, drive every output to 0: init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, protocol_err, wr_count and rd_count.
REQ-023 SHALL, while rst_n is low, clear the calibration counter, stall counter, outstanding count and read pipeline.
REQ-024 SHALL not reset memory contents.
REQ-025 SHALL discard reads that are in flight when reset asserts; no valid pulse appears for them after reset release.

Verification
REQ-026 SHALL cover calibration: release reset, hold app_en low -> init_calib_complete rises at cycle 100 and app_rdy rises with it.
REQ-027 SHALL cover write-then-read: write data 0x5A at app_addr 0x40, then read 0x40 on the next accepted cycle -> app_rd_data 0x5A with valid exactly 4 cycles after read acceptance, rd_count 1.
REQ-028 SHALL cover backpressure: write 1000 sequential words (address step 8, data 0..999) while honouring ready -> wr_count 1000, no protocol_err; read back -> 1000 in-order matches.
REQ-029 SHALL cover the credit limit: MAX_OUTSTANDING=2, RD_LAT=6, read every cycle -> app_rdy low after 2 accepted reads, and exactly 1 read accepted per return thereafter.
REQ-030 SHALL cover protocol violations:
- app_cmd=3 with app_en -> protocol_err high next cycle, memory unchanged.
- app_wdf_wren without app_en -> protocol_err set.
REQ-031 SHALL cover aliasing and reset: with DEPTH=1024, write at 0x2000 then read at 0x0 -> same data; assert rst_n low during 3 in-flight reads -> no valid pulses, counts 0.
